// File: rtl/cam_timing_pkg.sv
// Shared constants, fr encoding and state type for the camera sync timing blocks.
package cam_timing_pkg;

  localparam int CAM_LINE_LEN    = 1064;
  localparam int CAM_FRAME_LINES = 1028;
  localparam int CAM_MIN_LINE    = 16;
  localparam int CAM_TRIM_MAX    = 64;

  localparam logic [1:0] FR_60  = 2'd0;
  localparam logic [1:0] FR_120 = 2'd1;
  localparam logic [1:0] FR_240 = 2'd2;
  localparam logic [1:0] FR_480 = 2'd3;

  typedef enum logic {
    ST_RESTART = 1'b0,
    ST_RUN     = 1'b1
  } cam_state_e;

  // Accumulate one uph/downh step into the trim, saturating at +/-CAM_TRIM_MAX.
  function automatic logic signed [7:0] trim_next(input logic signed [7:0] t,
                                                  input logic up, input logic dn);
    logic signed [8:0] s;
    logic signed [8:0] lim;
    lim = 9'(CAM_TRIM_MAX);
    s   = 9'(t) - $signed({8'd0, up}) + $signed({8'd0, dn});
    if (s > lim)
      s = lim;
    else if (s < -lim)
      s = -lim;
    return s[7:0];
  endfunction

endpackage

// File: rtl/cam_sync_timing_gen_if.sv
// Bus between the sync timing generator (master) and the external-sync comparator (slave).
interface cam_sync_timing_gen_if;
  import cam_timing_pkg::*;

  // fr/uph/downh are levels; beginsyn, th and tv are single-cycle pulses;
  // ah/av/cur_len are registered and valid every cycle. No backpressure.
  logic [1:0]  fr;
  logic        uph;
  logic        downh;
  logic        beginsyn;
  logic [10:0] ah;
  logic [10:0] av;
  logic        th;
  logic        tv;
  logic [10:0] cur_len;
  cam_state_e  state;

  modport master (
    input  fr, uph, downh, beginsyn,
    output ah, av, th, tv, cur_len, state
  );

  modport slave (
    output fr, uph, downh, beginsyn,
    input  ah, av, th, tv, cur_len, state
  );

endinterface

// File: rtl/cam_line_len_calc.sv
// Effective line length: (LINE_LEN >> fr) - uph + downh + trim, clamped below at MIN_LINE.
module cam_line_len_calc #(
  parameter int LINE_LEN = 1064,
  parameter int MIN_LINE = 16
) (
  input  logic [1:0]        fr,
  input  logic              uph,
  input  logic              downh,
  input  logic signed [7:0] trim,
  output logic [10:0]       len
);

  localparam logic [12:0]        BASE_U = 13'(LINE_LEN);
  localparam logic signed [12:0] MIN_S  = 13'(MIN_LINE);

  logic signed [12:0] sum;

  always_comb begin
    sum = $signed(BASE_U >> fr) - $signed({12'd0, uph}) + $signed({12'd0, downh})
          + 13'(trim);
    len = (sum < MIN_S) ? 11'(MIN_LINE) : sum[10:0];
  end

endmodule

// File: rtl/cam_sync_timing_gen.sv
// Sensor line/frame timing generator with external-sync trim and restart.
// Optional persistent trim accumulator: define CAM_SYNC_TRIM_ACC_EN.
module cam_sync_timing_gen
  import cam_timing_pkg::*;
#(
  parameter int LINE_LEN    = CAM_LINE_LEN,
  parameter int FRAME_LINES = CAM_FRAME_LINES,
  parameter int MIN_LINE    = CAM_MIN_LINE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cam_sync_timing_gen_if.master bus
);

  cam_state_e state_q, state_d;

  logic [10:0] ah_q, ah_d;
  logic [10:0] av_q, av_d;
  logic [10:0] len_q, len_d;
  logic        th_q, th_d;
  logic        tv_q, tv_d;
  logic [1:0]  fr_q, fr_d;
  logic [1:0]  fr_sel;
  logic [10:0] calc_len;
  logic        do_restart;
  logic        line_end;
  logic        wrap;

`ifdef CAM_SYNC_TRIM_ACC_EN
  logic signed [7:0] trim_q, trim_d;

  always_comb trim_d = line_end ? trim_next(trim_q, bus.uph, bus.downh) : trim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trim_q <= '0;
    else        trim_q <= trim_d;
  end
`else
  logic signed [7:0] trim_q;
  assign trim_q = '0;
`endif

  // beginsyn restarts on the same edge it is sampled, so it is folded into do_restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RESTART;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESTART: state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_RESTART;
    endcase
  end

  assign do_restart = (state_q == ST_RESTART) || bus.beginsyn;
  assign line_end   = (state_q == ST_RUN) && (ah_q == len_q - 11'd1);
  assign wrap       = line_end && (av_q == 11'(FRAME_LINES - 1));
  // A new fr only takes effect on the line that starts with a tv.
  assign fr_sel     = (do_restart || wrap) ? bus.fr : fr_q;

  cam_line_len_calc #(
    .LINE_LEN (LINE_LEN),
    .MIN_LINE (MIN_LINE)
  ) u_len (
    .fr    (fr_sel),
    .uph   (bus.uph),
    .downh (bus.downh),
    .trim  (trim_q),
    .len   (calc_len)
  );

  always_comb begin
    ah_d  = ah_q + 11'd1;
    av_d  = av_q;
    len_d = len_q;
    fr_d  = fr_q;
    th_d  = 1'b0;
    tv_d  = 1'b0;
    if (do_restart) begin
      ah_d  = '0;
      av_d  = '0;
      th_d  = 1'b1;
      tv_d  = 1'b1;
      fr_d  = fr_sel;
      len_d = calc_len;
    end else if (line_end) begin
      ah_d  = '0;
      av_d  = wrap ? 11'd0 : av_q + 11'd1;
      th_d  = 1'b1;
      tv_d  = wrap;
      fr_d  = fr_sel;
      len_d = calc_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ah_q  <= '0;
      av_q  <= '0;
      th_q  <= 1'b0;
      tv_q  <= 1'b0;
      len_q <= 11'(LINE_LEN);
      fr_q  <= FR_60;
    end else begin
      ah_q  <= ah_d;
      av_q  <= av_d;
      th_q  <= th_d;
      tv_q  <= tv_d;
      len_q <= len_d;
      fr_q  <= fr_d;
    end
  end

  assign bus.ah      = ah_q;
  assign bus.av      = av_q;
  assign bus.th      = th_q;
  assign bus.tv      = tv_q;
  assign bus.cur_len = len_q;
  assign bus.state   = state_q;

endmodule
